// File: rtl/ras_if.sv
// ---------------------------------------------------------------------------
// ras_if : request/response bundle between the predecode stage and the
//          return-address stack.
//
// Signals (named from the stack's point of view):
//   flush_i         empty the stack (checkpoint kept)
//   push_i          call detected, push data_i
//   pop_i           return detected, pop top
//   data_i          return address to push
//   ckpt_save_i     capture top-of-stack checkpoint
//   ckpt_restore_i  restore stack from checkpoint
//   data_o          predicted return address (0 when empty)
//   valid_o         stack non-empty
//   overflow_o      one-cycle pulse, push overwrote oldest entry
//   underflow_o     one-cycle pulse, pop on empty stack
//
// Modports: master = frontend driving requests, slave = the stack.
// ---------------------------------------------------------------------------
interface ras_if #(
    parameter int XLEN = 32
);
    logic            flush_i;
    logic            push_i;
    logic            pop_i;
    logic [XLEN-1:0] data_i;
    logic            ckpt_save_i;
    logic            ckpt_restore_i;
    logic [XLEN-1:0] data_o;
    logic            valid_o;
    logic            overflow_o;
    logic            underflow_o;

    modport master (
        output flush_i, push_i, pop_i, data_i, ckpt_save_i, ckpt_restore_i,
        input  data_o, valid_o, overflow_o, underflow_o
    );

    modport slave (
        input  flush_i, push_i, pop_i, data_i, ckpt_save_i, ckpt_restore_i,
        output data_o, valid_o, overflow_o, underflow_o
    );
endinterface

// File: rtl/ras_circular.sv
// ---------------------------------------------------------------------------
// ras_circular : parametrised circular return-address stack for the frontend
//                branch predictor.
//
// Storage is a circular buffer of RAS_DEPTH entries. A push on a full stack
// silently overwrites the oldest entry (flagged by overflow_o). A
// single-level checkpoint of {ptr, count, top entry} allows repair after a
// mispredict flush; only the top entry is repaired on restore.
//
// Ports:
//   clk_i   clock, all state updates on the rising edge
//   rst_i   synchronous active-high reset, clears all state incl. checkpoint
//   bus     ras_if.slave (requests in, prediction and pulses out)
//
// Configuration macro:
//   RAS_CKPT_EN  defined   -> checkpoint save/restore functional
//                undefined -> ckpt_save_i / ckpt_restore_i ignored, no
//                             checkpoint registers
//
// Priority: rst_i > flush_i > ckpt_restore_i > push/pop.
// ---------------------------------------------------------------------------
module ras_circular #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 2,
    parameter int PTR_W     = $clog2(RAS_DEPTH),
    parameter int CNT_W     = $clog2(RAS_DEPTH + 1)
) (
    input  logic    clk_i,
    input  logic    rst_i,
    ras_if.slave    bus
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    // Stack state
    logic [XLEN-1:0]  mem_q [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q,  ptr_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic             ovf_q,  ovf_d;
    logic             udf_q,  udf_d;

    // Single write port into the buffer
    logic             mem_we;
    logic [PTR_W-1:0] mem_waddr;
    logic [XLEN-1:0]  mem_wdata;

    logic             empty;
    logic             full;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CNT_FULL);

`ifdef RAS_CKPT_EN
    logic [PTR_W-1:0] ckpt_ptr_q, ckpt_ptr_d;
    logic [CNT_W-1:0] ckpt_cnt_q, ckpt_cnt_d;
    logic [XLEN-1:0]  ckpt_top_q, ckpt_top_d;
`else
    logic unused_ckpt;
    assign unused_ckpt = bus.ckpt_save_i ^ bus.ckpt_restore_i;
`endif

    // -----------------------------------------------------------------------
    // Next-state logic for pointer, count, buffer write and pulses
    // -----------------------------------------------------------------------
    always_comb begin
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        ovf_d     = 1'b0;
        udf_d     = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = ptr_q;
        mem_wdata = bus.data_i;

        if (bus.flush_i) begin
            ptr_d = '0;
            cnt_d = '0;
        end
`ifdef RAS_CKPT_EN
        else if (bus.ckpt_restore_i) begin
            // Top-entry repair: only the checkpointed slot is rewritten.
            ptr_d     = ckpt_ptr_q;
            cnt_d     = ckpt_cnt_q;
            mem_we    = 1'b1;
            mem_waddr = ckpt_ptr_q;
            mem_wdata = ckpt_top_q;
        end
`endif
        else if (bus.push_i && bus.pop_i && !empty) begin
            // Return-and-call: replace the top in place.
            mem_we    = 1'b1;
            mem_waddr = ptr_q;
        end
        else if (bus.push_i) begin
            // Also covers push+pop on an empty stack.
            ptr_d     = ptr_q + PTR_ONE;
            mem_we    = 1'b1;
            mem_waddr = ptr_q + PTR_ONE;
            cnt_d     = full ? cnt_q : cnt_q + CNT_ONE;
            ovf_d     = full;
        end
        else if (bus.pop_i) begin
            if (!empty) begin
                ptr_d = ptr_q - PTR_ONE;
                cnt_d = cnt_q - CNT_ONE;
            end else begin
                udf_d = 1'b1;
            end
        end
    end

`ifdef RAS_CKPT_EN
    // -----------------------------------------------------------------------
    // Checkpoint capture: pre-update state, blocked by a same-cycle restore
    // so the restore sees the old checkpoint. Flush does not block it.
    // -----------------------------------------------------------------------
    always_comb begin
        ckpt_ptr_d = ckpt_ptr_q;
        ckpt_cnt_d = ckpt_cnt_q;
        ckpt_top_d = ckpt_top_q;
        if (bus.ckpt_save_i && !bus.ckpt_restore_i) begin
            ckpt_ptr_d = ptr_q;
            ckpt_cnt_d = cnt_q;
            ckpt_top_d = mem_q[ptr_q];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ckpt_ptr_q <= '0;
            ckpt_cnt_q <= '0;
            ckpt_top_q <= '0;
        end else begin
            ckpt_ptr_q <= ckpt_ptr_d;
            ckpt_cnt_q <= ckpt_cnt_d;
            ckpt_top_q <= ckpt_top_d;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
            if (mem_we) begin
                mem_q[mem_waddr] <= mem_wdata;
            end
        end
    end

    // Prediction is combinational from registered state.
    assign bus.data_o      = empty ? '0 : mem_q[ptr_q];
    assign bus.valid_o     = !empty;
    assign bus.overflow_o  = ovf_q;
    assign bus.underflow_o = udf_q;

endmodule
